ld_scalar_mult: RTL and testbench

- Sequential controller that computes the scalar multiple kP of a Lopez-Dahab projective point over GF(2^4).
- Acts as the initiator for the combinational point ALU, which has the interface op/A/B -> R, with op=0 for add and op=1 for double.
- Uses left-to-right double-and-add. Each ALU operation is issued in one cycle and its result is captured at the next rising edge.
- Sits between the key/point registers and the existing point ALU instance.

---
 rtl/ld_scalar_mult.sv | 112 +++++++++++
 tb/tb_ld_scalar_mult.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ld_scalar_mult.sv
// Left-to-right double-and-add controller computing kP by driving an external
// Lopez-Dahab point ALU; one ALU op per busy cycle, result taken at the next edge.
module ld_scalar_mult #(
  parameter int          KW        = 4,
  parameter logic [11:0] INF_POINT = 12'h006
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [11:0]   p,
  output logic          busy,
  output logic          done,
  output logic [11:0]   result,
  output logic          alu_op,
  output logic [11:0]   alu_a,
  output logic [11:0]   alu_b,
  input  logic [11:0]   alu_r
);

  localparam int IW = (KW > 1) ? $clog2(KW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DBL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [11:0]     r_p;
  logic [11:0]     r_q;
  logic [IW-1:0]   r_idx;
  logic [11:0]     r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_p      <= '0;
      r_q      <= INF_POINT;
      r_idx    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k     <= k;
            r_p     <= p;
            r_q     <= INF_POINT;
            r_idx   <= IW'(KW - 1);
            r_state <= S_DBL;
          end
        end
        S_DBL: begin
          r_q <= alu_r;
          // A set bit keeps idx for the following ADD, which then steps it.
          if (r_k[r_idx]) begin
            r_state <= S_ADD;
          end else if (r_idx == '0) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        S_ADD: begin
          r_q <= alu_r;
          if (r_idx == '0) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx - 1'b1;
            r_state <= S_DBL;
          end
        end
        S_DONE: begin
          r_result <= r_q;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ALU operands are decoded from registered state; alu_r closes the loop in the same cycle.
  always_comb begin
    alu_op = 1'b0;
    alu_a  = '0;
    alu_b  = '0;
    busy   = 1'b0;
    done   = 1'b0;
    result = r_result;
    case (r_state)
      S_DBL: begin
        alu_op = 1'b1;
        alu_a  = r_q;
        busy   = 1'b1;
      end
      S_ADD: begin
        alu_a = r_p;
        alu_b = r_q;
        busy  = 1'b1;
      end
      S_DONE: begin
        done   = 1'b1;
        result = r_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ld_scalar_mult.sv
// Bench for ld_scalar_mult: abstract group ALU (O=0x006 is the identity), scoreboard of
// expected results, busy-cycle counts and ALU op sequences, checked by a monitor.
module tb_ld_scalar_mult;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k;
  logic [11:0]   p;
  logic          busy, done, alu_op;
  logic [11:0]   result, alu_a, alu_b, alu_r;

  ld_scalar_mult #(.KW(KW), .INF_POINT(12'h006)) dut (
    .clk(clk), .rst(rst), .start(start), .k(k), .p(p),
    .busy(busy), .done(done), .result(result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: the group x -> x-6 (mod 4096), so O+P=P and 2O=O hold.
  always_comb begin
    if (alu_op) alu_r = (alu_a << 1) - 12'h006;
    else        alu_r = alu_a + alu_b - 12'h006;
  end

  typedef struct {
    logic [11:0] res;
    int          nbusy;
    logic [31:0] ops;
    int          nops;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic [KW-1:0] kk, input logic [11:0] pp);
    exp_t e;
    logic [11:0] d;
    d = pp - 12'h006;
    e.res   = 12'(int'(kk) * int'(d) + 6);
    e.nbusy = 0;
    e.ops   = '0;
    e.nops  = 0;
    for (int i = KW - 1; i >= 0; i--) begin
      e.ops = {e.ops[30:0], 1'b1};
      e.nops++;
      if (kk[i]) begin
        e.ops = {e.ops[30:0], 1'b0};
        e.nops++;
      end
    end
    e.nbusy = e.nops;
    return e;
  endfunction

  // Monitor
  int          mon_busy = 0;
  logic [31:0] mon_ops = '0;
  int          mon_nops = 0;
  logic [11:0] held = '0;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 0;
      mon_ops  = '0;
      mon_nops = 0;
      held     = '0;
    end else begin
      if (busy) begin
        mon_busy++;
        mon_ops = {mon_ops[30:0], alu_op};
        mon_nops++;
      end
      if (done) begin
        done_cnt++;
        chk("busy_low_at_done", {31'b0, busy}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", {20'b0, result}, {20'b0, e.res});
          chk("busy_cycles", mon_busy, e.nbusy);
          chk("op_count", mon_nops, e.nops);
          chk("op_sequence", mon_ops, e.ops);
        end
        held     = result;
        mon_busy = 0;
        mon_ops  = '0;
        mon_nops = 0;
      end else begin
        chk("result_hold", {20'b0, result}, {20'b0, held});
      end
    end
  end

  task automatic wait_done();
    int c0;
    c0 = done_cnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != c0) return;
    end
    chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [KW-1:0] kk, input logic [11:0] pp);
    @(negedge clk);
    start = 1'b1;
    k     = kk;
    p     = pp;
    sb.push_back(ref_model(kk, pp));
    @(negedge clk);
    start = 1'b0;
    k     = ~kk;
    p     = ~pp;
    wait_done();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   {31'b0, busy},   32'd0);
    chk({tag, "_done"},   {31'b0, done},   32'd0);
    chk({tag, "_result"}, {20'b0, result}, 32'd0);
    chk({tag, "_alu_op"}, {31'b0, alu_op}, 32'd0);
    chk({tag, "_alu_a"},  {20'b0, alu_a},  32'd0);
    chk({tag, "_alu_b"},  {20'b0, alu_b},  32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    k     = '0;
    p     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // Abort a k=F run with a two-cycle reset
    @(negedge clk);
    start = 1'b1; k = 4'hF; p = 12'h138;
    @(negedge clk);
    start = 1'b0;
    chk("abort_run_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_idle_outputs("abort");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);

    run_op(4'd1, 12'h138);
    run_op(4'd2, 12'h138);
    run_op(4'd3, 12'h138);
    run_op(4'd0, 12'h138);
    run_op(4'hF, 12'h138);

    // Start held high: one run, then a second accepted in the IDLE cycle after done
    @(negedge clk);
    start = 1'b1; k = 4'd3; p = 12'h138;
    sb.push_back(ref_model(4'd3, 12'h138));
    sb.push_back(ref_model(4'd3, 12'h138));
    wait_done();
    @(negedge clk);
    #1;
    chk("b2b_idle_gap", {31'b0, busy}, 32'd0);
    @(negedge clk);
    #1;
    chk("b2b_second_accepted", {31'b0, busy}, 32'd1);
    start = 1'b0;
    wait_done();

    for (int i = 0; i < 20; i++) begin
      run_op(KW'($urandom), 12'($urandom));
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
